lemming_tracker: RTL and testbench

Downstream consumer of the Lemmings walker FSM status outputs (walk_left, walk_right, aaah, digging). Tracks horizontal position, depth below start, and current fall duration. Flags a splat when a fall lasts longer than a programmable limit. Feeds the scoreboard/display logic with registered position and status.

---
 rtl/lemming_tracker.sv | 134 +++++++++++++
 tb/tb_lemming_tracker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lemming_tracker.sv
// Tracks a Lemming's x position, dig depth and fall length from walker status; flags splats.
// Latency 1 cycle (all outputs registered); no backpressure. Optional revive port: TRACKER_REVIVE_EN.
module lemming_tracker #(
  parameter int POS_W       = 8,
  parameter int X_INIT      = 128,
  parameter int DEPTH_W     = 8,
  parameter int FALL_W      = 5,
  parameter int SPLAT_LIMIT = 20,
  parameter int DIG_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               walk_left,
  input  logic               walk_right,
  input  logic               aaah,
  input  logic               digging,
`ifdef TRACKER_REVIVE_EN
  input  logic               revive,
`endif
  output logic [POS_W-1:0]   x_pos,
  output logic [DEPTH_W-1:0] depth,
  output logic [FALL_W-1:0]  fall_cnt,
  output logic               land,
  output logic               splat,
  output logic               err
);

  localparam int DIG_W = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIG_CYCLES - 1);
  localparam logic [FALL_W-1:0] FALL_LIM  = FALL_W'(SPLAT_LIMIT);
  localparam logic [POS_W-1:0]  X_RESET   = POS_W'(X_INIT);

  typedef enum logic [1:0] {ALIVE, FALLING, SPLAT} state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   x_d;
  logic [DEPTH_W-1:0] depth_d;
  logic [FALL_W-1:0]  fall_d;
  logic [DIG_W-1:0]   dig_cnt, dig_d;
  logic               land_d, splat_d, err_d;
  logic               apply_alive;
  logic [2:0]         n_hi;

  assign n_hi = 3'(walk_left) + 3'(walk_right) + 3'(aaah) + 3'(digging);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ALIVE;
      x_pos    <= X_RESET;
      depth    <= '0;
      fall_cnt <= '0;
      dig_cnt  <= '0;
      land     <= 1'b0;
      splat    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_pos    <= x_d;
      depth    <= depth_d;
      fall_cnt <= fall_d;
      dig_cnt  <= dig_d;
      land     <= land_d;
      splat    <= splat_d;
      err      <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_pos;
    depth_d     = depth;
    fall_d      = fall_cnt;
    dig_d       = dig_cnt;
    land_d      = 1'b0;
    splat_d     = splat;
    err_d       = err;
    apply_alive = 1'b0;

    // An illegal status combination freezes everything for that cycle.
    if (n_hi > 3'd1) begin
      err_d = 1'b1;
    end else begin
      case (state_q)
        ALIVE: apply_alive = 1'b1;
        FALLING: begin
          if (aaah) begin
            if (fall_cnt != '1) fall_d = fall_cnt + 1'b1;
            if (depth != '1) depth_d = depth + 1'b1;
          end else begin
            fall_d = '0;
            if (fall_cnt > FALL_LIM) begin
              state_d = SPLAT;
              splat_d = 1'b1;
            end else begin
              state_d     = ALIVE;
              land_d      = 1'b1;
              apply_alive = 1'b1;
            end
          end
        end
        SPLAT: begin
`ifdef TRACKER_REVIVE_EN
          if (revive) begin
            state_d = ALIVE;
            splat_d = 1'b0;
            fall_d  = '0;
          end
`endif
        end
        default: state_d = ALIVE;
      endcase
    end

    // Walk/dig/fall-start actions, shared by ALIVE and a survived landing.
    if (apply_alive) begin
      dig_d = '0;
      if (walk_left && x_pos != '0) x_d = x_pos - 1'b1;
      if (walk_right && x_pos != '1) x_d = x_pos + 1'b1;
      if (digging) begin
        if (dig_cnt == DIG_LAST) begin
          if (depth != '1) depth_d = depth + 1'b1;
        end else begin
          dig_d = dig_cnt + 1'b1;
        end
      end
      if (aaah) begin
        state_d = FALLING;
        fall_d  = FALL_W'(1);
        if (depth != '1) depth_d = depth + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lemming_tracker.sv
// Randomised + scripted bench for lemming_tracker, checked each cycle against a behavioural model.
module tb_lemming_tracker;
  localparam int XMAX = 255, DMAX = 255, FMAX = 31, LIMIT = 20, DIGN = 4;

  logic clk = 1'b0, rst_n = 1'b1;
  logic walk_left = 1'b0, walk_right = 1'b0, aaah = 1'b0, digging = 1'b0, revive = 1'b0;
  logic [7:0] x_pos, depth;
  logic [4:0] fall_cnt;
  logic land, splat, err;

  lemming_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah), .digging(digging),
`ifdef TRACKER_REVIVE_EN
    .revive(revive),
`endif
    .x_pos(x_pos), .depth(depth), .fall_cnt(fall_cnt),
    .land(land), .splat(splat), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // Model: mode 0 alive, 1 falling, 2 dead.
  int m_x, m_depth, m_fall, m_dig, m_mode;
  bit m_land, m_err;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 128; m_depth = 0; m_fall = 0; m_dig = 0; m_mode = 0; m_land = 0; m_err = 0;
  endtask

  task automatic alive_apply();
    if (walk_left)  m_x = (m_x > 0) ? m_x - 1 : 0;
    if (walk_right) m_x = (m_x < XMAX) ? m_x + 1 : XMAX;
    if (digging) begin
      m_dig++;
      if (m_dig == DIGN) begin
        m_dig = 0;
        m_depth = (m_depth < DMAX) ? m_depth + 1 : DMAX;
      end
    end else begin
      m_dig = 0;
    end
    if (aaah) begin
      m_mode = 1; m_fall = 1;
      m_depth = (m_depth < DMAX) ? m_depth + 1 : DMAX;
    end
  endtask

  task automatic model_step();
    int n;
    n = $countones({walk_left, walk_right, aaah, digging});
    m_land = 0;
    if (n > 1) begin
      m_err = 1;
    end else if (m_mode == 0) begin
      alive_apply();
    end else if (m_mode == 1) begin
      if (aaah) begin
        m_fall  = (m_fall < FMAX) ? m_fall + 1 : FMAX;
        m_depth = (m_depth < DMAX) ? m_depth + 1 : DMAX;
      end else if (m_fall > LIMIT) begin
        m_mode = 2; m_fall = 0;
      end else begin
        m_mode = 0; m_fall = 0; m_land = 1;
        alive_apply();
      end
    end else begin
`ifdef TRACKER_REVIVE_EN
      if (revive) begin
        m_mode = 0; m_fall = 0;
      end
`endif
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    #1;
    chk("x_pos", x_pos, m_x);
    chk("depth", depth, m_depth);
    chk("fall_cnt", fall_cnt, m_fall);
    chk("land", land, m_land);
    chk("splat", splat, (m_mode == 2) ? 1 : 0);
    chk("err", err, m_err);
  end

  // Apply one input pattern {walk_left, walk_right, aaah, digging} for one cycle; starts/ends at negedge.
  task automatic drive(input logic [3:0] v, input int n = 1);
    for (int i = 0; i < n; i++) begin
      {walk_left, walk_right, aaah, digging} = v;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    {walk_left, walk_right, aaah, digging} = 4'b0000;
    revive = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_x_pos", x_pos, 128);
    chk("rst_depth", depth, 0);
    chk("rst_fall_cnt", fall_cnt, 0);
    chk("rst_land", land, 0);
    chk("rst_splat", splat, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_random(input int cycles);
    int i, r, len;
    logic [3:0] v;
    i = 0;
    while (i < cycles) begin
      r = $urandom_range(0, 99);
      revive = ($urandom_range(0, 7) == 0);
      len = 1;
      if (r < 4) begin
        v = 4'($urandom_range(0, 15));
        while ($countones(v) < 2) v = 4'($urandom_range(0, 15));
        drive(v);
      end else if (r < 40) begin
        len = $urandom_range(1, 8);
        drive(($urandom_range(0, 1) != 0) ? 4'b1000 : 4'b0100, len);
      end else if (r < 60) begin
        len = $urandom_range(1, 10);
        drive(4'b0001, len);
      end else if (r < 78) begin
        len = $urandom_range(1, 28);
        drive(4'b0010, len);
      end else begin
        drive(4'b0000);
      end
      i += len;
    end
    revive = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    do_reset();

    // Walking and digging.
    drive(4'b0100, 5); chk("walk_right_5", x_pos, 133);
    drive(4'b1000, 2); chk("walk_left_2", x_pos, 131);
    chk("walk_depth", depth, 0); chk("walk_err", err, 0);
    drive(4'b0001, 9); chk("dig_9", depth, 2);
    drive(4'b0000);
    drive(4'b0001, 3); chk("dig_idle_3", depth, 2);
    drive(4'b0001);    chk("dig_4th", depth, 3);

    // Survivable fall of exactly the limit.
    drive(4'b0010, 20); chk("fall_20_cnt", fall_cnt, 20); chk("fall_20_depth", depth, 23);
    drive(4'b0000); chk("land_pulse", land, 1); chk("land_fall_clr", fall_cnt, 0); chk("land_splat", splat, 0);
    drive(4'b0000); chk("land_once", land, 0);

    // Position saturation.
    drive(4'b1000, 134); chk("x_sat_low", x_pos, 0);
    drive(4'b0100, 258); chk("x_sat_high", x_pos, 255);

    // Illegal inputs: sticky err, no update.
    drive(4'b1001); chk("illegal_err", err, 1); chk("illegal_x", x_pos, 255); chk("illegal_depth", depth, 23);
    drive(4'b1000); chk("err_sticky", err, 1); chk("post_err_x", x_pos, 254);

    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      run_random(300);
    end

    // Fatal fall, frozen counters afterwards.
    do_reset();
    drive(4'b0010, 21); chk("fall_21_cnt", fall_cnt, 21); chk("fall_21_depth", depth, 21);
    drive(4'b0000); chk("splat_set", splat, 1); chk("splat_land", land, 0); chk("splat_fall_clr", fall_cnt, 0);
    drive(4'b0100, 3); chk("splat_frozen_x", x_pos, 128); chk("splat_sticky", splat, 1);
    drive(4'b0110); chk("splat_err", err, 1);
`ifdef TRACKER_REVIVE_EN
    revive = 1'b1; drive(4'b0000); revive = 1'b0;
    chk("revive_splat", splat, 0); chk("revive_depth", depth, 21); chk("revive_land", land, 0);
    drive(4'b0100); chk("revive_walk", x_pos, 129);
`endif

    // Long fall saturates fall_cnt and still splats.
    do_reset();
    drive(4'b0010, 40); chk("fall_sat", fall_cnt, 31); chk("fall_sat_depth", depth, 40);
    drive(4'b0000); chk("fall_sat_splat", splat, 1);

    // Reset mid-fall.
    do_reset();
    drive(4'b0010, 10); chk("midfall_cnt", fall_cnt, 10);
    do_reset();
    drive(4'b0000, 2); chk("midfall_no_land", land, 0); chk("midfall_no_splat", splat, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
